// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU definitions: add/sub opcode encodings, status-flag
//            bit positions, serial-unit state encoding and opcode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings. Bit 0 set means B is inverted (subtract family).
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    // Bit positions inside status_flags ({V,C,S,Z}).
    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Serial control state encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // True for SUB/SBC: B enters the adder inverted (two's complement via c0).
    function automatic logic op_is_sub(input logic [1:0] op);
        return op[0];
    endfunction

    // Initial carry into the least significant digit.
    function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
        case (op)
            OP_ADD:  return 1'b0;
            OP_SUB:  return 1'b1;
            default: return cin;
        endcase
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/addsub_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : addsub_serial_if
// Purpose  : Request/response bundle between the ALU dispatch and the
//            digit-serial add/subtract unit.
// Signals  : start, op[1:0], cin, a[WIDTH-1:0], b[WIDTH-1:0]  (to unit)
//            busy, done, result[WIDTH-1:0], status_flags[3:0] (from unit)
// Modports : master (dispatch side), slave (unit side)
// Revision : 1.0 - initial release
// ============================================================================
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       status_flags;

    modport master (
        output start, op, cin, a, b,
        input  busy, done, result, status_flags
    );

    modport slave (
        input  start, op, cin, a, b,
        output busy, done, result, status_flags
    );
endinterface : addsub_serial_if
`default_nettype wire

// File: rtl/addsub_serial_digit.sv
`default_nettype none
// ============================================================================
// Module   : addsub_digit
// Purpose  : Combinational DIGIT-bit adder slice used by the serial unit.
// Ports    : a[DIGIT-1:0]    operand A digit
//            beff[DIGIT-1:0] effective (possibly inverted) operand B digit
//            cin             carry into the digit
//            sum[DIGIT-1:0]  digit sum
//            cout            carry out of the digit
//            msb_cin         carry into the digit's top bit (overflow detect)
// Revision : 1.0 - initial release
// ============================================================================
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] beff,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);
    logic [DIGIT:0] total;

    assign total   = {1'b0, a} + {1'b0, beff} + (DIGIT+1)'(cin);
    assign sum     = total[DIGIT-1:0];
    assign cout    = total[DIGIT];
    // Recover the carry entering the top bit from that bit's sum equation.
    assign msb_cin = sum[DIGIT-1] ^ a[DIGIT-1] ^ beff[DIGIT-1];
endmodule : addsub_digit
`default_nettype wire

// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : addsub_serial
// Purpose  : Digit-serial WIDTH-bit ADD/SUB/ADC/SBC unit, DIGIT bits per
//            cycle, LSB digit first, with registered result and {V,C,S,Z}.
// Ports    : clk  rising-edge clock
//            rst  synchronous active-high reset
//            bus  addsub_serial_if.slave (start/op/cin/a/b in,
//                 busy/done/result/status_flags out)
// Revision : 1.0 - initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    addsub_serial_if.slave bus
);
    import alu_pkg::*;

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addsub_serial: DIGIT must be >= 1 and divide WIDTH");
    end

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic             sub_mode;
    logic             zero_acc;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] beff_dig;
    logic [DIGIT-1:0] sum_dig;
    logic             cout_dig;
    logic             msb_cin_dig;
    logic [WIDTH-1:0] res_next;
    logic             zero_next;
    logic             last;

    assign a_dig    = a_sh[DIGIT-1:0];
    assign beff_dig = b_sh[DIGIT-1:0] ^ {DIGIT{sub_mode}};

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a       (a_dig),
        .beff    (beff_dig),
        .cin     (carry),
        .sum     (sum_dig),
        .cout    (cout_dig),
        .msb_cin (msb_cin_dig)
    );

    // Result digits enter at the top and walk down, so after N digits the
    // first (least significant) digit has reached bit 0.
    assign res_next  = (res_sh >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
    assign zero_next = zero_acc & (sum_dig == '0);
    assign last      = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            sub_mode <= 1'b0;
            zero_acc <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        res_sh   <= '0;
                        sub_mode <= op_is_sub(bus.op);
                        carry    <= op_carry_in(bus.op, bus.cin);
                        zero_acc <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    a_sh     <= a_sh >> DIGIT;
                    b_sh     <= b_sh >> DIGIT;
                    res_sh   <= res_next;
                    carry    <= cout_dig;
                    zero_acc <= zero_next;
                    cnt      <= cnt + CNT_W'(1);
                    if (last) begin
                        result_q         <= res_next;
                        flags_q[FLAG_Z]  <= zero_next;
                        flags_q[FLAG_S]  <= sum_dig[DIGIT-1];
                        flags_q[FLAG_C]  <= cout_dig;
                        // Signed overflow: carry into MSB differs from carry out.
                        flags_q[FLAG_V]  <= cout_dig ^ msb_cin_dig;
                        done_q           <= 1'b1;
                        cnt              <= '0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy         = (state == ST_BUSY);
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.status_flags = flags_q;
endmodule : addsub_serial
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_serial
// Purpose  : Self-checking bench for addsub_serial. Five instances with
//            WIDTH=16 and DIGIT = 1,2,4,8,16 share one stimulus stream and
//            are compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_serial;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int NI = 5;    // instance i uses DIGIT = 1 << i
    localparam int D4 = 2;    // index of the DIGIT=4 instance

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;
    logic [W-1:0]  res_v [NI];
    logic [3:0]    flg_v [NI];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] got_res [NI];
    logic [3:0]   got_flg [NI];
    int           got_lat [NI];
    int           got_cnt [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        addsub_serial_if #(.WIDTH(W)) bus ();
        assign bus.start = start;
        assign bus.op    = op;
        assign bus.cin   = cin;
        assign bus.a     = a;
        assign bus.b     = b;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign res_v[g]  = bus.result;
        assign flg_v[g]  = bus.status_flags;

        addsub_serial #(
            .WIDTH (W),
            .DIGIT (1 << g)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain WIDTH+1-bit arithmetic on whole operands.
    function automatic void model(input logic [1:0] o, input logic ci,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [3:0] f);
        logic [W-1:0] be;
        logic [W:0]   s;
        logic         c0;
        c0 = (o == OP_ADD) ? 1'b0 : (o == OP_SUB) ? 1'b1 : ci;
        be = (o == OP_SUB || o == OP_SBC) ? ~y : y;
        s  = {1'b0, x} + {1'b0, be} + (W+1)'(c0);
        r  = s[W-1:0];
        f[FLAG_Z] = (r == '0);
        f[FLAG_S] = r[W-1];
        f[FLAG_C] = s[W];
        f[FLAG_V] = (x[W-1] == be[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until every instance is idle, then one more cycle.
    task automatic drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (busy_v == '0) break;
            tick;
        end
        check(tag, 32'(busy_v), 32'd0);
        tick;
    endtask

    // One operation on all instances; checks latency, pulse count, result,
    // flags and that the outputs held their old value while busy.
    task automatic run_op(input logic [1:0] o, input logic ci,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic [3:0]   ef;
        logic [W-1:0] prev [NI];
        logic [3:0]   prevf [NI];
        bit           held [NI];
        model(o, ci, x, y, er, ef);
        for (int i = 0; i < NI; i++) begin
            prev[i] = res_v[i]; prevf[i] = flg_v[i]; held[i] = 1'b1;
            got_cnt[i] = 0; got_lat[i] = -1;
        end
        start = 1'b1; op = o; cin = ci; a = x; b = y;
        tick;                                   // E0
        start = 1'b0;
        for (int i = 0; i < NI; i++)
            check($sformatf("busy_d%0d", 1 << i), 32'(busy_v[i]), 32'd1);
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            tick;
            for (int i = 0; i < NI; i++) begin
                if (done_v[i]) begin
                    got_cnt[i]++;
                    if (got_lat[i] < 0) begin
                        got_lat[i] = cyc;
                        got_res[i] = res_v[i];
                        got_flg[i] = flg_v[i];
                    end
                end else if (got_lat[i] < 0 && (res_v[i] !== prev[i] || flg_v[i] !== prevf[i])) begin
                    held[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("lat_d%0d", 1 << i),   32'(got_lat[i]), 32'(W >> i));
            check($sformatf("npulse_d%0d", 1 << i), 32'(got_cnt[i]), 32'd1);
            check($sformatf("res_d%0d op%0d a%h b%h", 1 << i, o, x, y), 32'(got_res[i]), 32'(er));
            check($sformatf("flg_d%0d op%0d a%h b%h", 1 << i, o, x, y), 32'(got_flg[i]), 32'(ef));
            check($sformatf("hold_d%0d", 1 << i),  32'(held[i]), 32'd1);
        end
    endtask

    task automatic directed(input string tag, input logic [1:0] o, input logic ci,
                            input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] er, input logic [3:0] ef);
        run_op(o, ci, x, y);
        check({tag, "_res"}, 32'(got_res[D4]), 32'(er));
        check({tag, "_flg"}, 32'(got_flg[D4]), 32'(ef));
    endtask

    initial begin
        int nd, d1c, d2c;
        logic [W-1:0] d1r, d2r;
        logic b4, b5;
        logic [W-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = OP_ADD; cin = 1'b0; a = '0; b = '0;
        repeat (3) tick;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_busy_d%0d", 1 << i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_done_d%0d", 1 << i), 32'(done_v[i]), 32'd0);
            check($sformatf("rst_res_d%0d", 1 << i),  32'(res_v[i]),  32'd0);
            check($sformatf("rst_flg_d%0d", 1 << i),  32'(flg_v[i]),  32'd0);
        end
        rst = 1'b0;
        tick;

        // Flags are {V,C,S,Z}.
        directed("add_ovf", OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010);
        directed("sub_eq",  OP_SUB, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b0101);
        directed("sub_brw", OP_SUB, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010);
        directed("sbc",     OP_SBC, 1'b0, 16'h1000, 16'h0001, 16'h0FFE, 4'b0100);
        directed("adc",     OP_ADC, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101);

        // start pulsed while busy must be ignored (DIGIT=4 instance).
        start = 1'b1; op = OP_ADD; cin = 1'b0; a = 16'h1234; b = 16'h0101;
        tick;                                   // E0
        start = 1'b0;
        tick;                                   // E1
        start = 1'b1; op = OP_SUB; a = 16'hFFFF; b = 16'h1111;
        tick;                                   // E2 sees start while busy
        start = 1'b0;
        nd = 0; d1c = -1; d1r = '0;
        for (int cyc = 3; cyc <= 12; cyc++) begin
            tick;
            if (done_v[D4]) begin
                if (nd == 0) begin d1c = cyc; d1r = res_v[D4]; end
                nd++;
            end
        end
        check("ign_npulse", 32'(nd), 32'd1);
        check("ign_lat",    32'(d1c), 32'd4);
        check("ign_res",    32'(d1r), 32'h1335);
        drain("ign_drain");

        // start held high through done: second op starts at EN+1.
        start = 1'b1; op = OP_ADD; cin = 1'b0; a = 16'h0001; b = 16'h0002;
        tick;                                   // E0
        a = 16'h0003; b = 16'h0004;
        nd = 0; d1c = -1; d2c = -1; d1r = '0; d2r = '0; b4 = 1'b1; b5 = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick;
            if (done_v[D4]) begin
                if (nd == 0) begin d1c = cyc; d1r = res_v[D4]; end
                else if (nd == 1) begin d2c = cyc; d2r = res_v[D4]; end
                nd++;
            end
            if (cyc == 4) b4 = busy_v[D4];
            if (cyc == 5) begin b5 = busy_v[D4]; start = 1'b0; end
        end
        check("b2b_npulse", 32'(nd),  32'd2);
        check("b2b_lat1",   32'(d1c), 32'd4);
        check("b2b_res1",   32'(d1r), 32'h0003);
        check("b2b_busy4",  32'(b4),  32'd0);
        check("b2b_busy5",  32'(b5),  32'd1);
        check("b2b_lat2",   32'(d2c), 32'd9);
        check("b2b_res2",   32'(d2r), 32'h0007);
        drain("b2b_drain");

        // Reset in the middle of a SUB.
        start = 1'b1; op = OP_SUB; cin = 1'b0; a = 16'h0009; b = 16'h0003;
        tick;                                   // E0
        start = 1'b0;
        tick;                                   // E1
        rst = 1'b1;
        tick;                                   // E2 sees rst
        rst = 1'b0;
        check("rstmid_busy", 32'(busy_v), 32'd0);
        check("rstmid_done", 32'(done_v), 32'd0);
        check("rstmid_res",  32'(res_v[D4]), 32'd0);
        check("rstmid_flg",  32'(flg_v[D4]), 32'd0);
        nd = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick;
            if (done_v != '0) nd++;
        end
        check("rstmid_nodone", 32'(nd), 32'd0);
        directed("after_rst", OP_ADD, 1'b0, 16'h0102, 16'h0304, 16'h0406, 4'b0000);

        // Randomised sweep with boundary operands mixed in.
        for (int t = 0; t < 1000; t++) begin
            case ($urandom_range(0, 7))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                2: ra = 16'h8000;
                3: ra = 16'h7FFF;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: rb = 16'h8000;
                3: rb = 16'h0001;
                default: rb = W'($urandom);
            endcase
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule : tb_addsub_serial
`default_nettype wire
